// File: rtl/abend_collector.sv
`default_nettype none
// ============================================================================
// Module      : abend_collector
// Description : Collects exit codes from Kiwi thread exit ports. The lowest
//               requesting thread wins each cycle. A real abend code (neither
//               0x00 nor 0xFF) is captured and frozen. The finished flag then
//               rises after a fixed settle delay.
// Revision    : 1.0 - initial release
// ============================================================================
module abend_collector #(
    parameter int NTHREADS  = 4,
    parameter int SETTLE    = 8,
    parameter int CTR_WIDTH = 32
) (
    input  logic                                        my_clock,
    input  logic                                        my_reset,
    input  logic [NTHREADS-1:0]                         thread_exit_req,
    input  logic [8*NTHREADS-1:0]                       thread_syndrome,
    output logic [NTHREADS-1:0]                         thread_exit_ack,
    output logic [7:0]                                  hpr_abend_syndrome,
    output logic                                        finished,
    output logic [((NTHREADS > 1) ? $clog2(NTHREADS) : 1)-1:0] exit_thread,
    output logic [CTR_WIDTH-1:0]                        run_cycles
);

    localparam int       c_IDX_W     = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
    localparam logic [7:0] c_SETTLE_LD = 8'(SETTLE);
    localparam logic [7:0] c_SYN_RUN   = 8'hFF;
    localparam logic [7:0] c_SYN_NONE  = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NTHREADS-1:0]    r_ack;
    logic [NTHREADS-1:0]    w_ack_nxt;
    logic [7:0]             r_syndrome;
    logic [7:0]             w_syndrome_nxt;
    logic                   r_finished;
    logic                   w_finished_nxt;
    logic [c_IDX_W-1:0]     r_exit_thread;
    logic [c_IDX_W-1:0]     w_exit_thread_nxt;
    logic [CTR_WIDTH-1:0]   r_run_cycles;
    logic [CTR_WIDTH-1:0]   w_run_cycles_nxt;
    logic [CTR_WIDTH-1:0]   w_run_cycles_inc;
    logic [7:0]             r_settle_cnt;
    logic [7:0]             w_settle_cnt_nxt;

    logic                   w_found;
    logic [c_IDX_W-1:0]     w_win_idx;
    logic [7:0]             w_win_code;
    logic [NTHREADS-1:0]    w_win_onehot;
    logic                   w_win_is_abend;

    // Fixed-priority arbiter: scan from the top so the lowest index overwrites last.
    always_comb begin
        w_found      = 1'b0;
        w_win_idx    = '0;
        w_win_code   = 8'h00;
        w_win_onehot = '0;
        for (int i = NTHREADS - 1; i >= 0; i--) begin
            if (thread_exit_req[i]) begin
                w_found         = 1'b1;
                w_win_idx       = c_IDX_W'(i);
                w_win_code      = thread_syndrome[8*i +: 8];
                w_win_onehot    = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // 0x00 and 0xFF are "still running" markers, so they never count as an abend.
    assign w_win_is_abend = (w_win_code != c_SYN_NONE) && (w_win_code != c_SYN_RUN);

    // The cycle counter sticks at all-ones instead of wrapping.
    assign w_run_cycles_inc = (r_run_cycles == {CTR_WIDTH{1'b1}}) ?
                              r_run_cycles : (r_run_cycles + CTR_WIDTH'(1));

    // Next-state and next-output logic. Every register holds by default.
    always_comb begin
        w_state_nxt       = r_state;
        w_ack_nxt         = '0;
        w_syndrome_nxt    = r_syndrome;
        w_finished_nxt    = r_finished;
        w_exit_thread_nxt = r_exit_thread;
        w_run_cycles_nxt  = r_run_cycles;
        w_settle_cnt_nxt  = r_settle_cnt;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt    = ST_RUN;
                w_syndrome_nxt = c_SYN_RUN;
            end
            ST_RUN: begin
                w_run_cycles_nxt = w_run_cycles_inc;
                if (w_found) begin
                    w_ack_nxt = w_win_onehot;
                    if (w_win_is_abend) begin
                        w_syndrome_nxt    = w_win_code;
                        w_exit_thread_nxt = w_win_idx;
                        w_settle_cnt_nxt  = c_SETTLE_LD;
                        w_state_nxt       = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt <= 8'd1) begin
                    w_settle_cnt_nxt = 8'd0;
                    w_finished_nxt   = 1'b1;
                    w_state_nxt      = ST_DONE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt - 8'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset wins over any pending request.
    always_ff @(posedge my_clock) begin
        if (my_reset) begin
            r_state       <= ST_IDLE;
            r_ack         <= '0;
            r_syndrome    <= c_SYN_NONE;
            r_finished    <= 1'b0;
            r_exit_thread <= '0;
            r_run_cycles  <= '0;
            r_settle_cnt  <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_ack         <= w_ack_nxt;
            r_syndrome    <= w_syndrome_nxt;
            r_finished    <= w_finished_nxt;
            r_exit_thread <= w_exit_thread_nxt;
            r_run_cycles  <= w_run_cycles_nxt;
            r_settle_cnt  <= w_settle_cnt_nxt;
        end
    end

    assign thread_exit_ack    = r_ack;
    assign hpr_abend_syndrome = r_syndrome;
    assign finished           = r_finished;
    assign exit_thread        = r_exit_thread;
    assign run_cycles         = r_run_cycles;

endmodule
`default_nettype wire
